// File: rtl/mem_pkg.sv
// Shared definitions for the store-buffered RAM front end: default widths,
// read FSM encoding and the store-buffer entry layout.
package mem_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    RESP   = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buf_mem_if_sb_fifo.sv
// Store-buffer FIFO: DEPTH entries of {addr, data} with a parallel address
// compare that returns the data of the youngest matching valid entry.
module sb_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = MEM_AW,
  parameter int unsigned DW    = MEM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o,
  input  logic [AW-1:0] match_addr_i,
  output logic          match_hit_o,
  output logic [DW-1:0] match_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q, count;
  logic [PW-1:0] slot;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_addr_o = mem_q[rd_ptr_q[PW-1:0]].addr;
  assign head_data_o = mem_q[rd_ptr_q[PW-1:0]].data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= '{addr: push_addr_i, data: push_data_i};
  end

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    match_hit_o  = 1'b0;
    match_data_o = '0;
    slot         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q[PW-1:0] + PW'(k);
      if (((PW+1)'(k) < count) && (mem_q[slot].addr == match_addr_i)) begin
        match_hit_o  = 1'b1;
        match_data_o = mem_q[slot].data;
      end
    end
  end

endmodule

// File: rtl/store_buf_mem_if.sv
// CPU-side front end of the word RAM: buffered stores drained in the
// background, loads forwarded from the buffer or read from the RAM.
module store_buf_mem_if
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = MEM_AW,
  parameter int unsigned DW    = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  output logic          cpu_busy,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_exc,
  output logic [AW-1:0] cpu_exc_addr,
  output logic [AW-1:0] mem_r_addr,
  output logic          mem_read,
  input  logic [DW-1:0] mem_r_line,
  input  logic          mem_rrdy,
  output logic [AW-1:0] mem_w_addr,
  output logic [DW-1:0] mem_w_line,
  output logic          mem_write,
  input  logic          mem_wrdy,
  input  logic          mem_exc
);

  rd_state_e     state_q;
  logic [AW-1:0] rd_addr_q, exc_addr_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q, exc_q;

  logic          full, empty, wr_pend, push, pop, rd_acc, drain_exc, rd_exc;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data, head_data;
  logic [AW-1:0] head_addr;

  sb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_addr_i (cpu_addr),
    .push_data_i (cpu_wdata),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .match_addr_i(cpu_addr),
    .match_hit_o (fwd_hit),
    .match_data_o(fwd_data)
  );

  assign wr_pend  = ~empty;
  assign cpu_busy = (state_q != IDLE) | (cpu_wr & full);
  assign push     = cpu_wr & ~cpu_busy;
  assign rd_acc   = cpu_rd & ~cpu_wr & (state_q == IDLE);

  // Masking with the ready keeps the RAM from seeing a second request on
  // the cycle it completes the first.
  assign mem_write  = wr_pend & ~mem_wrdy;
  assign mem_read   = (state_q == RD_MEM) & ~mem_rrdy;
  assign mem_w_addr = wr_pend ? head_addr : '0;
  assign mem_w_line = wr_pend ? head_data : '0;
  assign mem_r_addr = rd_addr_q;

  // A shared exc goes to the drain whenever a write is outstanding.
  assign drain_exc = mem_exc & mem_write & ~mem_rrdy;
  assign rd_exc    = (state_q == RD_MEM) & mem_exc & ~mem_rrdy & ~mem_write;
  assign pop       = (wr_pend & mem_wrdy) | drain_exc;

  assign cpu_rdata    = rdata_q;
  assign cpu_rvalid   = rvalid_q;
  assign cpu_exc      = exc_q;
  assign cpu_exc_addr = exc_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      exc_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      exc_q    <= 1'b0;
      if (drain_exc) begin
        exc_q      <= 1'b1;
        exc_addr_q <= head_addr;
      end
      unique case (state_q)
        IDLE: begin
          if (rd_acc) begin
            if (fwd_hit) begin
              rdata_q  <= fwd_data;
              rvalid_q <= 1'b1;
              state_q  <= RESP;
            end else begin
              rd_addr_q <= cpu_addr;
              state_q   <= RD_MEM;
            end
          end
        end
        RD_MEM: begin
          if (mem_rrdy) begin
            rdata_q  <= mem_r_line;
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end else if (rd_exc) begin
            exc_q      <= 1'b1;
            exc_addr_q <= rd_addr_q;
            rdata_q    <= '0;
            state_q    <= IDLE;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buf_mem_if.sv
// Bench for store_buf_mem_if: 1024-word RAM model behind the memory port,
// directed scenarios then random loads/stores against a CPU-view memory.
`timescale 1ns/1ps

module tb_store_buf_mem_if;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rd, cpu_wr, cpu_busy, cpu_rvalid, cpu_exc;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] cpu_exc_addr, mem_r_addr, mem_w_addr;
  logic          mem_read, mem_rrdy, mem_write, mem_wrdy, mem_exc;
  logic [DW-1:0] mem_r_line, mem_w_line;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  function automatic void chk(input string tag, input bit ok,
                              input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  always #5 clk = ~clk;

  store_buf_mem_if #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_busy    (cpu_busy),
    .cpu_rdata   (cpu_rdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_exc     (cpu_exc),
    .cpu_exc_addr(cpu_exc_addr),
    .mem_r_addr  (mem_r_addr),
    .mem_read    (mem_read),
    .mem_r_line  (mem_r_line),
    .mem_rrdy    (mem_rrdy),
    .mem_w_addr  (mem_w_addr),
    .mem_w_line  (mem_w_line),
    .mem_write   (mem_write),
    .mem_wrdy    (mem_wrdy),
    .mem_exc     (mem_exc)
  );

  // RAM model: level request, response (rrdy/wrdy or exc) one cycle later.
  logic [31:0] init_mem [0:1023];
  logic [31:0] ram_q    [0:1023];
  bit          ram_wv   [0:1023];
  logic [31:0] view     [0:1023];
  bit          ram_hold, rd_hold, stall_rand;
  logic        rrdy_r = 1'b0, wrdy_r = 1'b0, rexc_r = 1'b0, wexc_r = 1'b0;
  logic [31:0] rline_r = '0;
  sb_entry_t   exp_wq[$];
  sb_entry_t   drained_q[$];

  assign mem_rrdy   = rrdy_r;
  assign mem_wrdy   = wrdy_r;
  assign mem_exc    = rexc_r | wexc_r;
  assign mem_r_line = rline_r;

  function automatic logic [31:0] ram_rd(input logic [9:0] i);
    return ram_wv[i] ? ram_q[i] : init_mem[i];
  endfunction

  always @(posedge clk) begin
    sb_entry_t e;
    rrdy_r <= 1'b0;
    wrdy_r <= 1'b0;
    rexc_r <= 1'b0;
    wexc_r <= 1'b0;
    if (mem_read && !rrdy_r && !rexc_r && !rd_hold) begin
      if (mem_r_addr < 1024) begin
        rrdy_r  <= 1'b1;
        rline_r <= ram_rd(mem_r_addr[9:0]);
      end else rexc_r <= 1'b1;
    end
    if (mem_write && !wrdy_r && !wexc_r && !ram_hold &&
        !(stall_rand && ($urandom_range(0, 1) == 1))) begin
      e.addr = mem_w_addr;
      e.data = mem_w_line;
      drained_q.push_back(e);
      if (mem_w_addr < 1024) begin
        ram_q[mem_w_addr[9:0]]  <= mem_w_line;
        ram_wv[mem_w_addr[9:0]] <= 1'b1;
        wrdy_r                  <= 1'b1;
      end else wexc_r <= 1'b1;
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit also_rd);
    int unsigned n;
    sb_entry_t   e;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = also_rd;
    #1;
    n = 0;
    while (cpu_busy && n < 300) begin @(negedge clk); #1; n++; end
    chk("store_accept", cpu_busy === 1'b0, cpu_busy, 1'b0);
    e.addr = a; e.data = d;
    exp_wq.push_back(e);
    if (a < 1024) view[a[9:0]] = d;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output bit gv,
                         output bit ge, output int unsigned lat, output int unsigned rdc,
                         output bit busy_all);
    int unsigned n;
    @(negedge clk);
    cpu_addr = a; cpu_rd = 1'b1; cpu_wr = 1'b0;
    #1;
    n = 0;
    while (cpu_busy && n < 300) begin @(negedge clk); #1; n++; end
    chk("load_accept", cpu_busy === 1'b0, cpu_busy, 1'b0);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    d = '0; gv = 1'b0; ge = 1'b0; lat = 0; rdc = 0; busy_all = 1'b1;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cpu_rvalid) begin gv = 1'b1; d = cpu_rdata; end
      if (cpu_exc) ge = 1'b1;
      if (gv || ge) begin lat = i; break; end
      if (mem_read) rdc++;
      if (!cpu_busy) busy_all = 1'b0;
    end
    chk("load_done", (gv | ge) === 1'b1, gv | ge, 1'b1);
  endtask

  task automatic wait_drain();
    int unsigned n;
    sb_entry_t   e, g;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((mem_write || mem_wrdy || mem_exc || exp_wq.size() != drained_q.size()) && n < 2000);
    chk("drain_count", drained_q.size() === exp_wq.size(), drained_q.size(), exp_wq.size());
    while (exp_wq.size() > 0 && drained_q.size() > 0) begin
      e = exp_wq.pop_front();
      g = drained_q.pop_front();
      chk("drain_order", g === e, g, e);
    end
    exp_wq.delete();
    drained_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a;
    bit          gv, ge, ba;
    int unsigned lat, rdc, wc, rv, seen;

    for (int unsigned i = 0; i < 1024; i++) begin
      init_mem[i] = $urandom;
      view[i]     = init_mem[i];
    end
    init_mem[9] = 32'hCAFE;
    view[9]     = 32'hCAFE;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    ram_hold = 1'b0; rd_hold = 1'b0; stall_rand = 1'b0;

    @(negedge clk);
    chk("rst_busy", cpu_busy === 1'b0, cpu_busy, 1'b0);
    chk("rst_rvalid", cpu_rvalid === 1'b0, cpu_rvalid, 1'b0);
    chk("rst_rdata", cpu_rdata === 32'h0, cpu_rdata, 32'h0);
    chk("rst_exc", {cpu_exc, cpu_exc_addr} === 33'h0, {cpu_exc, cpu_exc_addr}, 33'h0);
    chk("rst_mem_outs", {mem_read, mem_write, mem_r_addr, mem_w_addr, mem_w_line} === 98'h0,
        {mem_read, mem_write, mem_r_addr, mem_w_addr, mem_w_line}, 98'h0);
    @(negedge clk);
    rst = 1'b0;

    // Store then drain
    do_store(32'd5, 32'hDEADBEEF, 1'b0);
    wc = 0;
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (mem_write) wc++;
      if (i == 2) chk("drain_head_addr", mem_w_addr === 32'd5, mem_w_addr, 32'd5);
      if (i == 3) chk("fifo_empty_after_2", {mem_write, mem_w_addr} === 33'h0,
                      {mem_write, mem_w_addr}, 33'h0);
    end
    chk("write_one_cycle", wc === 1, wc, 1);
    chk("ram5", ram_rd(10'd5) === 32'hDEADBEEF, ram_rd(10'd5), 32'hDEADBEEF);
    wait_drain();

    // Forwarding with the RAM write port stalled
    ram_hold = 1'b1;
    do_store(32'd7, 32'h11, 1'b0);
    do_store(32'd7, 32'h22, 1'b0);
    do_load(32'd7, d, gv, ge, lat, rdc, ba);
    chk("fwd_data", d === 32'h22, d, 32'h22);
    chk("fwd_latency", lat === 1, lat, 1);
    chk("fwd_no_read", rdc === 0, rdc, 0);
    ram_hold = 1'b0;
    wait_drain();

    // Miss read
    do_load(32'd9, d, gv, ge, lat, rdc, ba);
    chk("miss_data", d === 32'hCAFE, d, 32'hCAFE);
    chk("miss_valid", gv === 1'b1, gv, 1'b1);
    chk("miss_latency", lat === 3, lat, 3);
    chk("miss_read_cycles", rdc === 1, rdc, 1);
    chk("miss_busy", ba === 1'b1, ba, 1'b1);

    // Full stall
    ram_hold = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) do_store(32'd20 + k, $urandom, 1'b0);
    @(negedge clk);
    cpu_addr = 32'd24; cpu_wdata = 32'h5555_0024; cpu_wr = 1'b1;
    #1;
    chk("full_busy", cpu_busy === 1'b1, cpu_busy, 1'b1);
    ram_hold = 1'b0;
    do_store(32'd24, 32'h5555_0024, 1'b0);
    wait_drain();
    for (int unsigned k = 20; k <= 24; k++)
      chk("full_ram", ram_rd(k[9:0]) === view[k], ram_rd(k[9:0]), view[k]);

    // Out-of-range accesses
    do_load(32'd2000, d, gv, ge, lat, rdc, ba);
    chk("oor_rd_exc", {ge, gv} === 2'b10, {ge, gv}, 2'b10);
    chk("oor_rd_addr", cpu_exc_addr === 32'd2000, cpu_exc_addr, 32'd2000);
    chk("oor_rd_lat", lat === 3, lat, 3);
    @(negedge clk);
    chk("oor_exc_pulse", cpu_exc === 1'b0, cpu_exc, 1'b0);
    do_store(32'd1500, 32'h1234, 1'b0);
    seen = 0;
    for (int unsigned i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (cpu_exc) seen = 1;
    end
    chk("oor_wr_exc", seen === 1, seen, 1);
    chk("oor_wr_addr", cpu_exc_addr === 32'd1500, cpu_exc_addr, 32'd1500);
    do_store(32'd2000, 32'h4321, 1'b0);
    do_store(32'd11, 32'h55, 1'b0);
    wait_drain();
    chk("after_exc_ram11", ram_rd(10'd11) === 32'h55, ram_rd(10'd11), 32'h55);
    chk("oor_wr2_addr", cpu_exc_addr === 32'd2000, cpu_exc_addr, 32'd2000);

    // Simultaneous rd+wr is a store only
    do_store(32'd30, 32'hA5A5, 1'b1);
    rv = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_rvalid) rv++;
    end
    chk("rdwr_no_rvalid", rv === 0, rv, 0);
    wait_drain();
    chk("rdwr_ram30", ram_rd(10'd30) === 32'hA5A5, ram_rd(10'd30), 32'hA5A5);

    // Reset in the middle of a RAM read with stores buffered
    ram_hold = 1'b1; rd_hold = 1'b1;
    do_store(32'd100, 32'h100, 1'b0);
    do_store(32'd101, 32'h101, 1'b0);
    @(negedge clk);
    cpu_addr = 32'd9; cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    @(negedge clk);
    chk("midrd_read", mem_read === 1'b1, mem_read, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrd_rst_cpu", {cpu_busy, cpu_rvalid, cpu_exc, cpu_rdata, cpu_exc_addr} === 67'h0,
        {cpu_busy, cpu_rvalid, cpu_exc, cpu_rdata, cpu_exc_addr}, 67'h0);
    chk("midrd_rst_mem", {mem_read, mem_write, mem_r_addr, mem_w_addr, mem_w_line} === 98'h0,
        {mem_read, mem_write, mem_r_addr, mem_w_addr, mem_w_line}, 98'h0);
    ram_hold = 1'b0; rd_hold = 1'b0;
    exp_wq.delete(); drained_q.delete();
    view[100] = ram_rd(10'd100);
    view[101] = ram_rd(10'd101);
    @(negedge clk);
    rst = 1'b0;
    wc = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_write) wc++;
    end
    chk("midrd_fifo_empty", wc === 0, wc, 0);
    do_load(32'd9, d, gv, ge, lat, rdc, ba);
    chk("midrd_reload", d === 32'hCAFE, d, 32'hCAFE);

    // Random mix against the CPU-view memory
    stall_rand = 1'b1;
    for (int unsigned n = 0; n < 150; n++) begin
      a = 32'd200 + $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, $urandom, ($urandom_range(0, 7) == 0));
      end else begin
        do_load(a, d, gv, ge, lat, rdc, ba);
        chk("rand_valid", {gv, ge} === 2'b10, {gv, ge}, 2'b10);
        chk("rand_data", d === view[a[9:0]], d, view[a[9:0]]);
      end
    end
    stall_rand = 1'b0;
    wait_drain();
    for (int unsigned k = 200; k < 216; k++)
      chk("rand_ram", ram_rd(k[9:0]) === view[k], ram_rd(k[9:0]), view[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
